// File: rtl/dmem_lane_arb.sv
// Data-memory lane arbiter: serialises the lw/sw accesses of the two issue lanes
// onto a single-port data memory, lane 0 first, holding the bundle with stall
// until both accesses have finished, then pulsing load write-back.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a bundle; stall raised as soon as any lane requests
// ACC0  | lane 0 access in flight (or being rejected as misaligned)
// ACC1  | lane 1 access in flight (or being rejected as misaligned)
// DONE  | bundle finished; write-back pulses, pipeline released
module dmem_lane_arb #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rs,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  input  logic [4:0]        rd0,
  input  logic [4:0]        rd1,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              wb0_valid,
  output logic              wb1_valid,
  output logic [4:0]        wb0_addr,
  output logic [4:0]        wb1_addr,
  output logic [31:0]       wb0_data,
  output logic [31:0]       wb1_data,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        in_acc;
  logic        lane1_sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [4:0]  sel_rd;
  logic        misal;
  logic        expired;
  logic        ack_ok;
  logic        acc_finish;
  logic        lane_lw_ok;
  logic        go_done;

  logic        lw_ok0_q, lw_ok1_q;
  logic [31:0] lat_data0_q, lat_data1_q;
  logic [4:0]  lat_rd0_q, lat_rd1_q;
  logic        ok0_nx, ok1_nx;
  logic [31:0] data0_nx, data1_nx;
  logic [4:0]  rd0_nx, rd1_nx;

  // Address bits above the memory window wrap and are deliberately dropped.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{addr0[31:ADDR_W+2], addr1[31:ADDR_W+2]};

  // Lane selection, access qualification and memory-side outputs.
  always_comb begin
    in_acc     = (state_q == ACC0) || (state_q == ACC1);
    lane1_sel  = (state_q == ACC1);
    sel_we     = lane1_sel ? we1    : we0;
    sel_addr   = lane1_sel ? addr1  : addr0;
    sel_wdata  = lane1_sel ? wdata1 : wdata0;
    sel_rd     = lane1_sel ? rd1    : rd0;

    misal      = in_acc && (sel_addr[1:0] != 2'b00);
    expired    = in_acc && !misal && (cnt_q == TIMEOUT_CNT);
    // An ack landing in the expiry cycle still counts as a normal completion.
    ack_ok     = in_acc && !misal && mem_ack;
    acc_finish = in_acc && (misal || mem_ack || expired);
    lane_lw_ok = ack_ok && !sel_we && (sel_rd != 5'd0);

    mem_req    = in_acc && !misal && !expired;
    mem_we     = mem_req && sel_we;
    mem_addr   = mem_req ? sel_addr[ADDR_W+1:2] : '0;
    mem_wdata  = mem_req ? sel_wdata : 32'd0;

    stall      = ((state_q == IDLE) && (req0 || req1)) || in_acc;
  end

  // Next-state and timeout-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = 8'd0;
    case (state_q)
      IDLE: begin
        if (req0)      state_d = ACC0;
        else if (req1) state_d = ACC1;
      end
      ACC0: begin
        if (acc_finish) state_d = req1 ? ACC1 : DONE;
        else            cnt_d   = cnt_q + 8'd1;
      end
      ACC1: begin
        if (acc_finish) state_d = DONE;
        else            cnt_d   = cnt_q + 8'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    go_done = (state_d == DONE) && (state_q != DONE);
  end

  // Per-lane load results including the one completing this cycle, so the
  // write-back registers can be loaded on the way into DONE.
  always_comb begin
    ok0_nx   = lw_ok0_q;
    data0_nx = lat_data0_q;
    rd0_nx   = lat_rd0_q;
    ok1_nx   = lw_ok1_q;
    data1_nx = lat_data1_q;
    rd1_nx   = lat_rd1_q;
    if (lane_lw_ok && !lane1_sel) begin
      ok0_nx   = 1'b1;
      data0_nx = mem_rdata;
      rd0_nx   = sel_rd;
    end
    if (lane_lw_ok && lane1_sel) begin
      ok1_nx   = 1'b1;
      data1_nx = mem_rdata;
      rd1_nx   = sel_rd;
    end
  end

  // State, counter, error flag, latched load results and write-back registers.
  always_ff @(posedge clk) begin
    if (!rs) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      err         <= 1'b0;
      lw_ok0_q    <= 1'b0;
      lw_ok1_q    <= 1'b0;
      lat_data0_q <= 32'd0;
      lat_data1_q <= 32'd0;
      lat_rd0_q   <= 5'd0;
      lat_rd1_q   <= 5'd0;
      wb0_valid   <= 1'b0;
      wb1_valid   <= 1'b0;
      wb0_addr    <= 5'd0;
      wb1_addr    <= 5'd0;
      wb0_data    <= 32'd0;
      wb1_data    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (misal || (expired && !mem_ack)) err <= 1'b1;

      if (state_q == IDLE) begin
        lw_ok0_q <= 1'b0;
        lw_ok1_q <= 1'b0;
      end else begin
        lw_ok0_q    <= ok0_nx;
        lw_ok1_q    <= ok1_nx;
        lat_data0_q <= data0_nx;
        lat_data1_q <= data1_nx;
        lat_rd0_q   <= rd0_nx;
        lat_rd1_q   <= rd1_nx;
      end

      wb0_valid <= go_done && ok0_nx;
      wb1_valid <= go_done && ok1_nx;
      if (go_done && ok0_nx) begin
        wb0_addr <= rd0_nx;
        wb0_data <= data0_nx;
      end
      if (go_done && ok1_nx) begin
        wb1_addr <= rd1_nx;
        wb1_data <= data1_nx;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lane_arb.sv
// Bench for dmem_lane_arb: a memory responder with a scoreboard of expected
// accesses, a write-back scoreboard, and one task per scenario.
module tb_dmem_lane_arb;

  logic        clk, rs;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [4:0]  rd0, rd1;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        stall;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_addr, wb1_addr;
  logic [31:0] wb0_data, wb1_data;
  logic        err;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [36:0] wb0_q[$];
  logic [36:0] wb1_q[$];
  logic [31:0] mem_m [0:4095];

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;

  dmem_lane_arb #(.ADDR_W(12), .TIMEOUT(15)) dut (
    .clk(clk), .rs(rs),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rd0(rd0), .rd1(rd1),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall),
    .wb0_valid(wb0_valid), .wb1_valid(wb1_valid),
    .wb0_addr(wb0_addr), .wb1_addr(wb1_addr),
    .wb0_data(wb0_data), .wb1_data(wb1_data),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // Memory responder: acks ack_delay cycles after an access starts and checks
  // each completed access against the expected-access queue.
  initial begin : responder
    logic pending;
    int   rcnt;
    txn_t cur, exp_t;
    pending   = 1'b0;
    rcnt      = 0;
    cur       = '0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!pending) begin
          pending = 1'b1;
          rcnt    = 0;
          cur     = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
        end else begin
          rcnt++;
        end
      end else if (pending) begin
        rcnt++;
        if (rcnt != ack_delay) pending = 1'b0;
      end
      if (pending && (rcnt == ack_delay)) begin
        pending = 1'b0;
        mem_ack = 1'b1;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL mem_access_unexpected: got we=%0b addr=%h, expected none", cur.we, cur.addr);
        end else begin
          exp_t = exp_q.pop_front();
          if (cur.we !== exp_t.we || cur.addr !== exp_t.addr ||
              (exp_t.we && cur.wdata !== exp_t.wdata)) begin
            n_fail++;
            $display("FAIL mem_access: got we=%0b addr=%h wdata=%h, expected we=%0b addr=%h wdata=%h",
                     cur.we, cur.addr, cur.wdata, exp_t.we, exp_t.addr, exp_t.wdata);
          end
        end
        if (cur.we) begin
          mem_m[cur.addr] = cur.wdata;
          mem_rdata = 32'd0;
        end else begin
          mem_rdata = mem_m[cur.addr];
        end
      end
    end
  end

  // Write-back monitor: every wb pulse must match the next expected result.
  initial begin : wb_monitor
    logic [36:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (wb0_valid) begin
        n_checks++;
        if (wb0_q.size() == 0) begin
          n_fail++;
          $display("FAIL wb0_unexpected: got rd=%0d data=%h, expected no pulse", wb0_addr, wb0_data);
        end else begin
          e = wb0_q.pop_front();
          if ({wb0_addr, wb0_data} !== e) begin
            n_fail++;
            $display("FAIL wb0: got rd=%0d data=%h, expected rd=%0d data=%h", wb0_addr, wb0_data, e[36:32], e[31:0]);
          end
        end
      end
      if (wb1_valid) begin
        n_checks++;
        if (wb1_q.size() == 0) begin
          n_fail++;
          $display("FAIL wb1_unexpected: got rd=%0d data=%h, expected no pulse", wb1_addr, wb1_data);
        end else begin
          e = wb1_q.pop_front();
          if ({wb1_addr, wb1_data} !== e) begin
            n_fail++;
            $display("FAIL wb1: got rd=%0d data=%h, expected rd=%0d data=%h", wb1_addr, wb1_data, e[36:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic clear_lanes();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; rd0 = 0; rd1 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rs = 1'b0;
    clear_lanes();
    @(negedge clk);
    rs = 1'b1;
  endtask

  // Called right after driving a bundle at a negedge; returns at #1 into DONE.
  task automatic run_bundle(output int n_stall, output int n_memreq);
    n_stall  = 0;
    n_memreq = 0;
    #1;
    while (stall && n_stall < 200) begin
      n_stall++;
      if (mem_req) n_memreq++;
      @(negedge clk);
      #1;
    end
    n_checks++;
    if (n_stall >= 200) begin
      n_fail++;
      $display("FAIL bundle_bound: stall still high after %0d cycles, expected release", n_stall);
    end
  endtask

  task automatic end_bundle();
    clear_lanes();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int ns, nm;
    do_reset();
    #1;
    n_checks++;
    if ({stall, mem_req, mem_we, wb0_valid, wb1_valid, err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got stall=%0b req=%0b we=%0b wb0=%0b wb1=%0b err=%0b, expected all 0",
               stall, mem_req, mem_we, wb0_valid, wb1_valid, err);
    end
    n_checks++;
    if ({wb0_addr, wb0_data, wb1_addr, wb1_data, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got wb0=%0d/%h wb1=%0d/%h addr=%h, expected all 0",
               wb0_addr, wb0_data, wb1_addr, wb1_data, mem_addr);
    end
    ns = 0; nm = 0;
  endtask

  task automatic test_single_lw();
    int ns, nm;
    ack_delay = 0;
    mem_m[4] = 32'hDEADBEEF;
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 32'h10; rd0 = 5'd9;
    exp_q.push_back('{we: 1'b0, addr: 12'd4, wdata: 32'd0});
    wb0_q.push_back({5'd9, 32'hDEADBEEF});
    run_bundle(ns, nm);
    n_checks++;
    if (ns != 2) begin
      n_fail++;
      $display("FAIL single_lw_stall: got %0d cycles, expected 2", ns);
    end
    n_checks++;
    if (wb0_valid !== 1'b1 || wb1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_lw_wb: got wb0=%0b wb1=%0b in DONE, expected 1 0", wb0_valid, wb1_valid);
    end
    end_bundle();
  endtask

  task automatic test_addr_wrap();
    int ns, nm;
    ack_delay = 1;
    mem_m[6] = 32'h600DF00D;
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 32'hFFFF0018; rd0 = 5'd31;
    exp_q.push_back('{we: 1'b0, addr: 12'd6, wdata: 32'd0});
    wb0_q.push_back({5'd31, 32'h600DF00D});
    run_bundle(ns, nm);
    n_checks++;
    if (ns != 3 || nm != 2) begin
      n_fail++;
      $display("FAIL wrap_timing: got stall=%0d req=%0d, expected stall=3 req=2", ns, nm);
    end
    end_bundle();
  endtask

  task automatic test_sw_then_lw();
    int ns, nm;
    ack_delay = 0;
    mem_m[8] = 32'h11111111;
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h55; rd0 = 5'd2;
    req1 = 1; we1 = 0; addr1 = 32'h20; rd1 = 5'd10;
    exp_q.push_back('{we: 1'b1, addr: 12'd8, wdata: 32'h55});
    exp_q.push_back('{we: 1'b0, addr: 12'd8, wdata: 32'd0});
    wb1_q.push_back({5'd10, 32'h55});
    run_bundle(ns, nm);
    n_checks++;
    if (ns != 3 || nm != 2) begin
      n_fail++;
      $display("FAIL sw_lw_timing: got stall=%0d req=%0d, expected stall=3 req=2", ns, nm);
    end
    n_checks++;
    if (wb0_valid !== 1'b0 || wb1_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_lw_wb: got wb0=%0b wb1=%0b, expected 0 1", wb0_valid, wb1_valid);
    end
    end_bundle();
  endtask

  task automatic test_back_to_back();
    int ns, nm;
    ack_delay = 3;
    mem_m[64]  = 32'hA0A00001;
    mem_m[129] = 32'hB0B00002;
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 32'h100; rd0 = 5'd11;
    req1 = 1; we1 = 0; addr1 = 32'h204; rd1 = 5'd12;
    exp_q.push_back('{we: 1'b0, addr: 12'd64,  wdata: 32'd0});
    exp_q.push_back('{we: 1'b0, addr: 12'd129, wdata: 32'd0});
    wb0_q.push_back({5'd11, 32'hA0A00001});
    wb1_q.push_back({5'd12, 32'hB0B00002});
    run_bundle(ns, nm);
    n_checks++;
    if (ns != 9 || nm != 8) begin
      n_fail++;
      $display("FAIL b2b_timing: got stall=%0d req=%0d, expected stall=9 req=8", ns, nm);
    end
    n_checks++;
    if (wb0_valid !== 1'b1 || wb1_valid !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: got wb0=%0b wb1=%0b req=%0b, expected 1 1 0", wb0_valid, wb1_valid, mem_req);
    end
    // Requests still high through DONE must not start a new access.
    @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || wb0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_accept: got req=%0b wb0=%0b after DONE, expected 0 0", mem_req, wb0_valid);
    end
    end_bundle();
  endtask

  task automatic test_misaligned();
    int ns, nm;
    ack_delay = 0;
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 32'h13; rd0 = 5'd6;
    run_bundle(ns, nm);
    n_checks++;
    if (ns != 2 || nm != 0) begin
      n_fail++;
      $display("FAIL misal_timing: got stall=%0d req=%0d, expected stall=2 req=0", ns, nm);
    end
    n_checks++;
    if (err !== 1'b1 || wb0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL misal_err: got err=%0b wb0=%0b, expected 1 0", err, wb0_valid);
    end
    end_bundle();
    mem_m[12] = 32'h12345678;
    req1 = 1; we1 = 0; addr1 = 32'h30; rd1 = 5'd4;
    exp_q.push_back('{we: 1'b0, addr: 12'd12, wdata: 32'd0});
    wb1_q.push_back({5'd4, 32'h12345678});
    run_bundle(ns, nm);
    n_checks++;
    if (ns != 2 || wb1_valid !== 1'b1 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL misal_recover: got stall=%0d wb1=%0b err=%0b, expected 2 1 1", ns, wb1_valid, err);
    end
    end_bundle();
  endtask

  task automatic test_timeout();
    int ns, nm;
    do_reset();
    ack_delay = 1000;
    req0 = 1; we0 = 0; addr0 = 32'h40; rd0 = 5'd3;
    run_bundle(ns, nm);
    n_checks++;
    if (ns != 17 || nm != 15) begin
      n_fail++;
      $display("FAIL timeout_timing: got stall=%0d req=%0d, expected stall=17 req=15", ns, nm);
    end
    n_checks++;
    if (err !== 1'b1 || wb0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err: got err=%0b wb0=%0b, expected 1 0", err, wb0_valid);
    end
    end_bundle();
    do_reset();
    ack_delay = 15;
    mem_m[17] = 32'hCAFE0015;
    req0 = 1; we0 = 0; addr0 = 32'h44; rd0 = 5'd5;
    exp_q.push_back('{we: 1'b0, addr: 12'd17, wdata: 32'd0});
    wb0_q.push_back({5'd5, 32'hCAFE0015});
    run_bundle(ns, nm);
    n_checks++;
    if (ns != 17 || err !== 1'b0 || wb0_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_ack_wins: got stall=%0d err=%0b wb0=%0b, expected 17 0 1", ns, err, wb0_valid);
    end
    end_bundle();
  endtask

  task automatic test_reset_mid_access();
    int ns, nm;
    ack_delay = 2;
    mem_m[32] = 32'h0BAD0BAD;
    @(negedge clk);
    req1 = 1; we1 = 0; addr1 = 32'h80; rd1 = 5'd7;
    exp_q.push_back('{we: 1'b0, addr: 12'd32, wdata: 32'd0});
    @(negedge clk);
    @(negedge clk);
    rs = 1'b0;
    @(negedge clk);
    rs = 1'b1;
    req1 = 0;
    #1;
    n_checks++;
    if ({stall, mem_req, wb0_valid, wb1_valid, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got stall=%0b req=%0b wb0=%0b wb1=%0b err=%0b, expected all 0",
               stall, mem_req, wb0_valid, wb1_valid, err);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({stall, mem_req, wb1_valid, err} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_late_ack: got stall=%0b req=%0b wb1=%0b err=%0b, expected all 0",
               stall, mem_req, wb1_valid, err);
    end
    ack_delay = 0;
    mem_m[36] = 32'h77777777;
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 32'h90; rd0 = 5'd0;
    exp_q.push_back('{we: 1'b0, addr: 12'd36, wdata: 32'd0});
    run_bundle(ns, nm);
    n_checks++;
    if (ns != 2 || wb0_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd0_zero: got stall=%0d wb0=%0b, expected 2 0", ns, wb0_valid);
    end
    end_bundle();
  endtask

  initial begin
    rs = 1'b0;
    clear_lanes();
    for (int i = 0; i < 4096; i++) mem_m[i] = 32'd0;
    test_reset();
    test_single_lw();
    test_addr_wrap();
    test_sw_then_lw();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || wb0_q.size() != 0 || wb1_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got mem=%0d wb0=%0d wb1=%0d left, expected 0 0 0",
               exp_q.size(), wb0_q.size(), wb1_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
